// File: rtl/serial_adder_n_if.sv
// Handshake and operand/result bundle for serial_adder_n.
// Latency: none (wires only). Backpressure: start is ignored while busy is high.
// Ports: master drives start/a/b/c_in/sub; slave (the adder) drives busy/done/sum/c_out/overflow.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: DIGIT full-adder cells iterate LSB-first over a WIDTH-bit add.
// Latency: WIDTH/DIGIT cycles from the accepting edge to done; one result per WIDTH/DIGIT+1 cycles.
// Backpressure: start is sampled only in IDLE/DONE; a start during RUN is dropped.
// Ports: clk, rst (async, active-high); bus (slave) carries start/a/b/c_in/sub in and
//        busy/done/sum/c_out/overflow out. All outputs are registered.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  serial_adder_n_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic             carry, sub_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q, ovf_q;

  logic [DIGIT-1:0] digit;
  logic             c_next;    // carry out of the current digit
  logic             c_msb_in;  // carry into the top cell of the digit
  logic             last;
  logic             accept;

  assign last   = (cnt == CW'(N - 1));
  assign accept = bus.start && (state != RUN);

  // Chain of DIGIT full-adder cells over the low bits of the shift registers.
  // On the final digit the top cell is bit WIDTH-1, so c_msb_in feeds overflow.
  always_comb begin
    logic c;
    c        = carry;
    digit    = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb_in = c;
      digit[i] = a_sr[i] ^ b_sr[i] ^ c;
      c        = (a_sr[i] & b_sr[i]) | (c & (a_sr[i] ^ b_sr[i]));
    end
    c_next = c;
  end

  // New digit enters from the top; after N shifts the LSB digit sits at bit 0.
  always_comb begin
    res_next = (res_sr >> DIGIT) | (WIDTH'(digit) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      sub_q   <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1 - borrow_in, so the initial carry is c_in ^ sub.
      a_sr   <= bus.a;
      b_sr   <= bus.sub ? ~bus.b : bus.b;
      carry  <= bus.c_in ^ bus.sub;
      sub_q  <= bus.sub;
      cnt    <= '0;
      res_sr <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      res_sr <= res_next;
      carry  <= c_next;
      if (last) begin
        sum_q   <= res_next;
        c_out_q <= c_next ^ sub_q;  // borrow is the inverted carry
        ovf_q   <= c_msb_in ^ c_next;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Multi-cycle, parametrised adder/subtractor built on the full-adder cell. It processes DIGIT bits per clock, LSB first, and produces a WIDTH-bit result with carry/borrow and signed overflow after WIDTH/DIGIT cycles. A start/busy/done handshake lets a controller trade area (DIGIT full-adder cells instead of WIDTH) for latency. It sits in the arithmetic datapath wherever a wide add is needed but a full ripple-carry adder is too large.

## Interface
- WIDTH, 8: operand and result width in bits; must be a positive multiple of DIGIT.
- DIGIT, 1: bits processed per cycle; DIGIT = WIDTH gives a single-cycle add.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- c_in  input  1  carry-in (add) or borrow-in (sub); captured on the accepting edge.
- sub  input  1  0 = a+b+c_in, 1 = a-b-c_in; captured on the accepting edge.
- busy  output  1  high while state = RUN.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- sum  output  WIDTH  result, held until the next completion.
- c_out  output  1  carry-out (add) or borrow-out (sub).
- overflow  output  1  two's-complement signed overflow.

## Operation
- The FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE or DONE with start=1:**
  - Load the A shift register with a.
  - Load the B shift register with (sub ? ~b : b).
  - Set carry = c_in ^ sub.
  - Clear the digit counter and the result shift register.
  - Go to RUN.
- **IDLE with start=0:** stay in IDLE.
- **DONE with start=0:** go to IDLE.
- **RUN, each cycle:**
  - DIGIT chained full-adder cells add the low DIGIT bits of A and B plus carry.
  - Shift the digit into the result register from the top.
  - Shift A and B right by DIGIT.
  - Update carry and increment the counter.
- **RUN, final digit (counter = WIDTH/DIGIT-1):**
  - On the same edge, load sum, c_out and overflow.
  - Go to DONE.
- **Output rules:**
  - c_out = final carry when sub=0, ~final carry when sub=1 (borrow).
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- start while in RUN is ignored; there is no queueing and the operation in flight is unaffected.
- Operand inputs are don't-care except on the accepting edge.
- sum, c_out and overflow change only on the completion edge or on reset. They are never partially updated.
- Counter width is clog2(WIDTH/DIGIT), with a minimum of 1. The counter never wraps past WIDTH/DIGIT-1.
- **Reset (any state, including mid-RUN):** immediately aborts.
  - State goes to IDLE.
  - Counter, shift registers and carry are cleared.
  - sum, c_out, overflow, busy and done are all 0.

## Timing
- Let N = WIDTH/DIGIT. Call the accepting edge E0.
- busy is high from E0 until edge EN, i.e. N cycles.
- done is high for exactly one cycle, from EN to EN+1. sum, c_out and overflow are valid from EN.
- Back-to-back operation: start=1 during the done cycle is accepted at EN+1. Throughput is one result per N+1 cycles.
- done and busy are never high together.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Unsigned add (WIDTH=8, DIGIT=1):** a=0x5A, b=0x3C, c_in=0, sub=0 → sum=0x96, c_out=0, overflow=1. busy high for 8 cycles; done pulses on the 8th edge after accept.
- **Carry chain:** a=0xFF, b=0x01, c_in=1, sub=0 → sum=0x01, c_out=1, overflow=0.
- **Subtract:**
  - a=0x10, b=0x20, c_in=0, sub=1 → sum=0xF0, c_out(borrow)=1, overflow=0.
  - a=0x80, b=0x01, sub=1 → sum=0x7F, c_out=0, overflow=1.
- **Handshake:**
  - Pulse start with new operands mid-RUN → ignored; the first result is unchanged.
  - start asserted in the done cycle → the second op is accepted. Its done comes 9 cycles after the first done.
- **Reset mid-operation:** assert rst at RUN cycle 4 → all outputs 0 immediately, state IDLE. The next start (0x01+0x01) gives sum=0x02.
- **WIDTH=8, DIGIT=4:** 0xFF+0x01, c_in=0 → sum=0x00, c_out=1, overflow=0. busy is high 2 cycles.
